ring_counter_gen: RTL and testbench



---
 rtl/ring_counter_pkg.sv | 18 +
 rtl/shift_state_check.sv | 32 +++
 rtl/ring_counter_gen.sv | 112 +++++++++++
 tb/tb_ring_counter_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ring_counter_pkg.sv
// rtl/ring_counter_pkg.sv - shared types and seed constants for the ring/Johnson counter
package ring_counter_pkg;

  typedef enum logic {
    MODE_RING    = 1'b0,
    MODE_JOHNSON = 1'b1
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  // Seeds used when recovering from an illegal state (ring: LSB set, Johnson: all zeros)
  localparam int RING_SEED    = 1;
  localparam int JOHNSON_SEED = 0;

endpackage

// File: rtl/shift_state_check.sv
// rtl/shift_state_check.sv - combinational legality check of a ring/Johnson counter state
module shift_state_check
  import ring_counter_pkg::*;
#(
  parameter int NBITS = 4
) (
  input  logic [NBITS-1:0] count,
  input  mode_t            mode,
  output logic             illegal
);

  logic [31:0] ones;
  logic [31:0] edges;

  // Ring states hold exactly one set bit; Johnson states have at most one 0/1 boundary
  always_comb begin
    ones  = '0;
    edges = '0;
    for (int i = 0; i < NBITS; i++) begin
      ones = ones + {31'b0, count[i]};
    end
    for (int i = 0; i < NBITS - 1; i++) begin
      edges = edges + {31'b0, count[i] ^ count[i+1]};
    end
    if (mode == MODE_JOHNSON) begin
      illegal = (edges > 32'd1);
    end else begin
      illegal = (ones != 32'd1);
    end
  end

endmodule

// File: rtl/ring_counter_gen.sv
// rtl/ring_counter_gen.sv - parametrised ring/Johnson shift counter with position and wrap
// Optional macro RING_SELF_CORRECT_EN: an enabled step from an illegal state reloads the seed.
module ring_counter_gen
  import ring_counter_pkg::*;
#(
  parameter int NBITS = 4,
  parameter int NPOS  = $clog2(2 * NBITS)
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [NBITS-1:0] data_in,
  input  logic             mode,
  input  logic             dir,
  output logic [NBITS-1:0] count,
  output logic [NPOS-1:0]  pos,
  output logic             wrap,
  output logic             illegal
);

  localparam int PW = NPOS + 1;

  logic [NBITS-1:0] count_q, count_d;
  logic [NPOS-1:0]  pos_q, pos_d;
  logic             wrap_q, wrap_d;

  mode_t            mode_e;
  dir_t             dir_e;
  logic             feedback_inv;
  logic [PW-1:0]    period;
  logic [PW-1:0]    pos_ext;
  logic [NBITS-1:0] count_shift;
  logic [NPOS-1:0]  pos_step;

  assign mode_e       = mode_t'(mode);
  assign dir_e        = dir_t'(dir);
  assign feedback_inv = (mode_e == MODE_JOHNSON);
  assign period       = (mode_e == MODE_JOHNSON) ? PW'(2 * NBITS) : PW'(NBITS);
  assign pos_ext      = {1'b0, pos_q};

  shift_state_check #(
    .NBITS (NBITS)
  ) u_check (
    .count   (count_q),
    .mode    (mode_e),
    .illegal (illegal)
  );

  always_comb begin
    count_shift = count_q;
    pos_step    = pos_q;
    if (dir_e == DIR_LEFT) begin
      count_shift = {count_q[NBITS-2:0], count_q[NBITS-1] ^ feedback_inv};
      if (pos_ext >= period - PW'(1)) begin
        pos_step = '0;
      end else begin
        pos_step = pos_q + NPOS'(1);
      end
    end else begin
      count_shift = {count_q[0] ^ feedback_inv, count_q[NBITS-1:1]};
      // A stale pos beyond the current period (after a mode change) snaps to the top
      if ((pos_q == '0) || (pos_ext >= period)) begin
        pos_step = NPOS'(period - PW'(1));
      end else begin
        pos_step = pos_q - NPOS'(1);
      end
    end
  end

  always_comb begin
    count_d = count_q;
    pos_d   = pos_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = data_in;
      pos_d   = '0;
    end else if (en) begin
`ifdef RING_SELF_CORRECT_EN
      if (illegal) begin
        count_d = (mode_e == MODE_JOHNSON) ? NBITS'(JOHNSON_SEED) : NBITS'(RING_SEED);
        pos_d   = '0;
      end else begin
        count_d = count_shift;
        pos_d   = pos_step;
        wrap_d  = (pos_step == '0);
      end
`else
      count_d = count_shift;
      pos_d   = pos_step;
      wrap_d  = (pos_step == '0);
`endif
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      count_q <= '0;
      pos_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      pos_q   <= pos_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign pos   = pos_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_ring_counter_gen.sv
// tb/tb_ring_counter_gen.sv - scoreboard bench for ring_counter_gen against an arithmetic model
module tb_ring_counter_gen;

  localparam int N    = 4;
  localparam int NP   = $clog2(2 * N);
  localparam int MASK = (1 << N) - 1;

  logic          clk_2 = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [N-1:0]  data_in = '0;
  logic          mode = 1'b0;
  logic          dir = 1'b0;
  logic [N-1:0]  count;
  logic [NP-1:0] pos;
  logic          wrap;
  logic          illegal;

  typedef struct {
    int c;
    int p;
    bit w;
    bit ill;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_c = 0;
  int   m_p = 0;
  bit   m_w = 1'b0;

  ring_counter_gen #(.NBITS(N)) dut (
    .clk_2   (clk_2),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .data_in (data_in),
    .mode    (mode),
    .dir     (dir),
    .count   (count),
    .pos     (pos),
    .wrap    (wrap),
    .illegal (illegal)
  );

  always #5 clk_2 = ~clk_2;

  function automatic bit legal(input int c, input bit md);
    if (md) return $countones((c ^ (c >> 1)) & (MASK >> 1)) <= 1;
    return $countones(c & MASK) == 1;
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  task automatic advance(input bit md, input bit dr);
    int per;
    int fb;
    per = md ? 2 * N : N;
    if (!dr) begin
      fb  = ((m_c >> (N - 1)) & 1) ^ int'(md);
      m_c = ((m_c << 1) & MASK) | fb;
      m_p = (m_p >= per - 1) ? 0 : m_p + 1;
    end else begin
      fb  = (m_c & 1) ^ int'(md);
      m_c = (m_c >> 1) | (fb << (N - 1));
      m_p = (m_p == 0 || m_p >= per) ? per - 1 : m_p - 1;
    end
    m_w = (m_p == 0);
  endtask

  task automatic drive(input bit r, input bit l, input bit e, input int d, input bit md, input bit dr);
    exp_t x;
    @(negedge clk_2);
    reset   = r;
    load    = l;
    en      = e;
    data_in = d[N-1:0];
    mode    = md;
    dir     = dr;
    if (r) begin
      m_c = 0; m_p = 0; m_w = 0;
    end else if (l) begin
      m_c = d & MASK; m_p = 0; m_w = 0;
    end else if (e) begin
`ifdef RING_SELF_CORRECT_EN
      if (!legal(m_c, md)) begin
        m_c = md ? 0 : 1; m_p = 0; m_w = 0;
      end else begin
        advance(md, dr);
      end
`else
      advance(md, dr);
`endif
    end else begin
      m_w = 0;
    end
    x.c   = m_c;
    x.p   = m_p;
    x.w   = m_w;
    x.ill = !legal(m_c, md);
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk_2);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("count", int'(count), x.c);
        check("pos", int'(pos), x.p);
        check("wrap", int'(wrap), int'(x.w));
        check("illegal", int'(illegal), int'(x.ill));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit md;
    bit dr;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0);
    repeat (5) drive(0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 0);
    repeat (8) drive(0, 0, 1, 0, 1, 0);
    drive(0, 1, 0, 1, 0, 1);
    repeat (2) drive(0, 0, 1, 0, 0, 1);
    drive(0, 1, 0, 5, 0, 1);
    drive(0, 0, 0, 5, 0, 1);
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) drive(0, 0, 1, 0, 0, 0);
    drive(1, 1, 1, 3, 0, 0);
    drive(0, 1, 1, 4, 0, 0);
    drive(0, 1, 0, 1, 0, 0);
    repeat (2) drive(0, 0, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 0);
    repeat (6) drive(0, 0, 1, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    md = 0;
    dr = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) md = ~md;
      if ($urandom_range(0, 11) == 0) dr = ~dr;
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 7, int'($urandom_range(0, MASK)), md, dr);
    end
    drive(0, 0, 0, 0, md, dr);
    repeat (3) @(negedge clk_2);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
